// File: rtl/mul_pkg.sv
// Shared types for the sequential RV32M multiplier: op encoding (funct3[1:0]) and FSM states.
package mul_pkg;

  localparam int MUL_OP_W = 2;

  typedef enum logic [MUL_OP_W-1:0] {
    MUL    = 2'b00,
    MULH   = 2'b01,
    MULHSU = 2'b10,
    MULHU  = 2'b11
  } mul_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } mul_state_e;

  function automatic logic op_a_signed(input mul_op_e op);
    return (op == MULH) || (op == MULHSU);
  endfunction

  function automatic logic op_b_signed(input mul_op_e op);
    return (op == MULH);
  endfunction

endpackage

// File: rtl/FastAdder.sv
// Block carry-select adder: each block precomputes sums for carry-in 0 and 1,
// and the block carries ripple through the select muxes.
module FastAdder #(
  parameter int N           = 32,
  parameter int BLOCKCOUNT  = 8,
  parameter int BITPERBLOCK = 4
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_c,
  output logic [N-1:0] o_s,
  output logic         o_c
);

  localparam logic [BITPERBLOCK:0] ONE_B = {{BITPERBLOCK{1'b0}}, 1'b1};

  logic [BLOCKCOUNT:0] carry;

  assign carry[0] = i_c;

  for (genvar g = 0; g < BLOCKCOUNT; g++) begin : g_blk
    logic [BITPERBLOCK:0] sum0;
    logic [BITPERBLOCK:0] sum1;

    assign sum0 = {1'b0, i_a[g*BITPERBLOCK +: BITPERBLOCK]}
                + {1'b0, i_b[g*BITPERBLOCK +: BITPERBLOCK]};
    assign sum1 = sum0 + ONE_B;

    assign o_s[g*BITPERBLOCK +: BITPERBLOCK] = carry[g] ? sum1[BITPERBLOCK-1:0]
                                                        : sum0[BITPERBLOCK-1:0];
    assign carry[g+1] = carry[g] ? sum1[BITPERBLOCK] : sum0[BITPERBLOCK];
  end

  assign o_c = carry[BLOCKCOUNT];

endmodule

// File: rtl/seq_multiplier.sv
// Iterative radix-2 shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// Optional SEQ_MUL_ZERO_BYPASS_EN: zero operands skip straight to DONE with a zero result.
module seq_multiplier
  import mul_pkg::*;
#(
  parameter int N           = 32,
  parameter int BLOCKCOUNT  = 8,
  parameter int BITPERBLOCK = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [MUL_OP_W-1:0] i_op,
  input  logic [N-1:0]        i_a,
  input  logic [N-1:0]        i_b,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [N-1:0]        o_result,
  output logic                o_busy
);

  if (N != BLOCKCOUNT * BITPERBLOCK) begin : g_bad_cfg
    $fatal(1, "seq_multiplier: N must equal BLOCKCOUNT*BITPERBLOCK");
  end

  localparam int CNT_W = $clog2(N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [N-1:0]     ONE_N    = {{(N-1){1'b0}}, 1'b1};
  localparam logic [2*N-1:0]   ONE_2N   = {{(2*N-1){1'b0}}, 1'b1};

  mul_state_e     state_q;
  mul_op_e        op_q;
  logic [N-1:0]   mcand_q;
  logic [N-1:0]   mplier_q;
  logic [N-1:0]   acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic           neg_q;
  logic           valid_q;
  logic           ready_q;
  logic           busy_q;
  logic [N-1:0]   result_q;

  mul_op_e        op_in;
  logic           a_neg;
  logic           b_neg;
  logic [N-1:0]   a_abs_d;
  logic [N-1:0]   b_abs_d;
  logic [N-1:0]   add_b;
  logic [N-1:0]   sum;
  logic           sum_c;
  logic [N-1:0]   acc_d;
  logic [N-1:0]   mplier_d;
  logic [2*N-1:0] prod_fix_d;

  // Operands are magnitudes; the sign is reapplied on the full 2N product in FIX.
  always_comb begin
    op_in   = mul_op_e'(i_op);
    a_neg   = i_a[N-1] & op_a_signed(op_in);
    b_neg   = i_b[N-1] & op_b_signed(op_in);
    a_abs_d = a_neg ? (~i_a + ONE_N) : i_a;
    b_abs_d = b_neg ? (~i_b + ONE_N) : i_b;
  end

  assign add_b = mcand_q & {N{mplier_q[0]}};

  FastAdder #(
    .N           (N),
    .BLOCKCOUNT  (BLOCKCOUNT),
    .BITPERBLOCK (BITPERBLOCK)
  ) u_adder (
    .i_a (acc_q),
    .i_b (add_b),
    .i_c (1'b0),
    .o_s (sum),
    .o_c (sum_c)
  );

  always_comb begin
    acc_d      = {sum_c, sum[N-1:1]};
    mplier_d   = {sum[0], mplier_q[N-1:1]};
    prod_fix_d = {acc_q, mplier_q};
    if (neg_q) begin
      prod_fix_d = ~{acc_q, mplier_q} + ONE_2N;
    end
  end

  // o_valid is registered one cycle after entering DONE.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      op_q     <= MUL;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      result_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_valid && ready_q) begin
            op_q     <= op_in;
            mcand_q  <= a_abs_d;
            mplier_q <= b_abs_d;
            neg_q    <= a_neg ^ b_neg;
            acc_q    <= '0;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
`ifdef SEQ_MUL_ZERO_BYPASS_EN
            if ((i_a == '0) || (i_b == '0)) begin
              result_q <= '0;
              state_q  <= DONE;
            end else begin
              state_q  <= CALC;
            end
`else
            state_q  <= CALC;
`endif
          end
        end
        CALC: begin
          acc_q    <= acc_d;
          mplier_q <= mplier_d;
          cnt_q    <= cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          result_q <= (op_q == MUL) ? prod_fix_d[N-1:0] : prod_fix_d[2*N-1:N];
          state_q  <= DONE;
        end
        DONE: begin
          if (valid_q && i_ready) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            valid_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_valid  = valid_q;
  assign o_ready  = ready_q;
  assign o_busy   = busy_q;
  assign o_result = result_q;

endmodule
